// File: rtl/eeprom_spi_sequencer_if.sv
// Command/completion handshake and AXI-Lite master channels between the EEPROM
// sequencer and its environment.
interface eeprom_spi_sequencer_if;
    // Handshake rule: a transfer happens on every clock edge where VALID and READY
    // are both high; VALID never waits on READY, and payload is stable while VALID is up.
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [15:0] CMD_ADDR;
    logic [7:0]  CMD_WDATA;
    logic        DONE;
    logic [7:0]  RD_DATA;
    logic        ERROR;

    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
        output CMD_READY, DONE, RD_DATA, ERROR,
        output AWVALID, AWADDR, WVALID, WDATA, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, ARREADY, RVALID, RDATA
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
        input  CMD_READY, DONE, RD_DATA, ERROR,
        input  AWVALID, AWADDR, WVALID, WDATA, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, ARREADY, RVALID, RDATA
    );
endinterface

// File: rtl/eeprom_spi_sequencer.sv
// AXI-Lite master that drives the AXI-to-SPI peripheral through the full
// M25AA160C byte read / byte write framing, including WIP polling.
module eeprom_spi_sequencer #(
    parameter logic [31:0] BASE_ADDRESS  = 32'hFFFF0000,
    parameter logic [31:0] CMD_REG_VALUE = 32'h00000000,
    parameter int unsigned BUSY_BIT      = 0,
    parameter int unsigned END_BIT       = 8,
    parameter logic [15:0] POLL_LIMIT    = 16'd50000
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    eeprom_spi_sequencer_if.master        bus,
    output logic [2:0]                    dbg_state_o
);
    localparam logic [31:0] RX_ADDR  = BASE_ADDRESS + 32'h0;
    localparam logic [31:0] ST_ADDR  = BASE_ADDRESS + 32'h4;
    localparam logic [31:0] CMD_ADDR = BASE_ADDRESS + 32'h8;
    localparam logic [31:0] TX_ADDR  = BASE_ADDRESS + 32'hC;

    typedef enum logic [2:0] {S_CFG, S_IDLE, S_TX, S_WAIT, S_DRAIN, S_FIN} state_e;
    typedef enum logic [1:0] {FR_WREN, FR_WRITE, FR_READ, FR_RDSR} frame_e;

    state_e      state_q, state_d;
    frame_e      frame_q, frame_d;
    logic [1:0]  idx_q, idx_d;
    logic        is_write_q, is_write_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wbyte_q, wbyte_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        err_q, err_d;
    logic [7:0]  last_rx_q, last_rx_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        wr_busy_q, wr_busy_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] axi_wdata_q, axi_wdata_d;
    logic        rd_busy_q, rd_busy_d;
    logic        ar_valid_q, ar_valid_d;
    logic        r_ready_q, r_ready_d;
    logic [31:0] araddr_q, araddr_d;

    logic        aw_hs, w_hs, wr_done, rd_hs;
    logic        wr_start, rd_start;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [7:0]  tx_byte;
    logic        tx_end;
    logic [1:0]  last_idx;
    logic [31:0] tx_word;
    logic        unused_rdata;

    assign aw_hs        = aw_valid_q & bus.AWREADY;
    assign w_hs         = w_valid_q & bus.WREADY;
    assign wr_done      = wr_busy_q & (aw_done_q | aw_hs) & (w_done_q | w_hs);
    assign rd_hs        = r_ready_q & bus.RVALID;
    assign unused_rdata = ^bus.RDATA[31:8];

    // Byte table for each SPI frame; the final byte carries the CS-release flag.
    always_comb begin
        tx_byte  = 8'h00;
        tx_end   = 1'b0;
        last_idx = 2'd3;
        case (frame_q)
            FR_WREN: begin
                tx_byte  = 8'h06;
                tx_end   = 1'b1;
                last_idx = 2'd0;
            end
            FR_WRITE, FR_READ: begin
                case (idx_q)
                    2'd0:    tx_byte = (frame_q == FR_WRITE) ? 8'h02 : 8'h03;
                    2'd1:    tx_byte = addr_q[15:8];
                    2'd2:    tx_byte = addr_q[7:0];
                    default: begin
                        tx_byte = (frame_q == FR_WRITE) ? wbyte_q : 8'h00;
                        tx_end  = 1'b1;
                    end
                endcase
            end
            default: begin
                last_idx = 2'd1;
                if (idx_q == 2'd0) begin
                    tx_byte = 8'h05;
                end else begin
                    tx_byte = 8'h00;
                    tx_end  = 1'b1;
                end
            end
        endcase
        tx_word          = 32'd0;
        tx_word[7:0]     = tx_byte;
        tx_word[END_BIT] = tx_end;
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wbyte_d     = wbyte_q;
        poll_cnt_d  = poll_cnt_q;
        err_d       = err_q;
        last_rx_d   = last_rx_q;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        wr_busy_d   = wr_busy_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awaddr_d    = awaddr_q;
        axi_wdata_d = axi_wdata_q;
        rd_busy_d   = rd_busy_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        araddr_d    = araddr_q;
        wr_start    = 1'b0;
        rd_start    = 1'b0;
        wr_addr     = TX_ADDR;
        wr_data     = tx_word;
        rd_addr     = ST_ADDR;

        // Each channel drops its VALID independently once its own handshake lands.
        if (aw_hs) begin
            aw_valid_d = 1'b0;
            aw_done_d  = 1'b1;
        end
        if (w_hs) begin
            w_valid_d = 1'b0;
            w_done_d  = 1'b1;
        end
        if (wr_done) wr_busy_d = 1'b0;
        if (ar_valid_q && bus.ARREADY) begin
            ar_valid_d = 1'b0;
            r_ready_d  = 1'b1;
        end
        if (rd_hs) begin
            r_ready_d = 1'b0;
            rd_busy_d = 1'b0;
        end

        case (state_q)
            S_CFG: begin
                if (!wr_busy_q) begin
                    wr_start = 1'b1;
                    wr_addr  = CMD_ADDR;
                    wr_data  = CMD_REG_VALUE;
                end else if (wr_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.CMD_VALID) begin
                    is_write_d = bus.CMD_WRITE;
                    addr_d     = bus.CMD_ADDR;
                    wbyte_d    = bus.CMD_WDATA;
                    poll_cnt_d = 16'd0;
                    err_d      = 1'b0;
                    idx_d      = 2'd0;
                    frame_d    = bus.CMD_WRITE ? FR_WREN : FR_READ;
                    state_d    = S_TX;
                end
            end
            S_TX: begin
                if (!wr_busy_q) begin
                    wr_start = 1'b1;
                end else if (wr_done) begin
                    if (idx_q == last_idx) begin
                        idx_d   = 2'd0;
                        state_d = S_WAIT;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_WAIT: begin
                if (!rd_busy_q) begin
                    rd_start = 1'b1;
                    rd_addr  = ST_ADDR;
                end else if (rd_hs && !bus.RDATA[BUSY_BIT]) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!rd_busy_q) begin
                    rd_start = 1'b1;
                    rd_addr  = RX_ADDR;
                end else if (rd_hs) begin
                    last_rx_d = bus.RDATA[7:0];
                    if (idx_q == last_idx) begin
                        idx_d = 2'd0;
                        case (frame_q)
                            FR_WREN: begin
                                frame_d = FR_WRITE;
                                state_d = S_TX;
                            end
                            FR_WRITE: begin
                                frame_d = FR_RDSR;
                                state_d = S_TX;
                            end
                            FR_RDSR: begin
                                if (bus.RDATA[0]) begin
                                    poll_cnt_d = poll_cnt_q + 16'd1;
                                    if (poll_cnt_q + 16'd1 >= POLL_LIMIT) begin
                                        err_d   = 1'b1;
                                        state_d = S_FIN;
                                    end else begin
                                        state_d = S_TX;
                                    end
                                end else begin
                                    state_d = S_FIN;
                                end
                            end
                            default: state_d = S_FIN;
                        endcase
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                error_d = err_q;
                if (!is_write_q) rd_data_d = last_rx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_CFG;
        endcase

        if (wr_start) begin
            wr_busy_d   = 1'b1;
            aw_valid_d  = 1'b1;
            w_valid_d   = 1'b1;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
            awaddr_d    = wr_addr;
            axi_wdata_d = wr_data;
        end
        if (rd_start) begin
            rd_busy_d  = 1'b1;
            ar_valid_d = 1'b1;
            araddr_d   = rd_addr;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q     <= S_CFG;
            frame_q     <= FR_WREN;
            idx_q       <= 2'd0;
            is_write_q  <= 1'b0;
            addr_q      <= 16'd0;
            wbyte_q     <= 8'd0;
            poll_cnt_q  <= 16'd0;
            err_q       <= 1'b0;
            last_rx_q   <= 8'd0;
            rd_data_q   <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wr_busy_q   <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awaddr_q    <= 32'd0;
            axi_wdata_q <= 32'd0;
            rd_busy_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            araddr_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wbyte_q     <= wbyte_d;
            poll_cnt_q  <= poll_cnt_d;
            err_q       <= err_d;
            last_rx_q   <= last_rx_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            wr_busy_q   <= wr_busy_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awaddr_q    <= awaddr_d;
            axi_wdata_q <= axi_wdata_d;
            rd_busy_q   <= rd_busy_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            araddr_q    <= araddr_d;
        end
    end

    assign bus.CMD_READY = (state_q == S_IDLE);
    assign bus.DONE      = done_q;
    assign bus.ERROR     = error_q;
    assign bus.RD_DATA   = rd_data_q;
    assign bus.AWVALID   = aw_valid_q;
    assign bus.AWADDR    = awaddr_q;
    assign bus.WVALID    = w_valid_q;
    assign bus.WDATA     = axi_wdata_q;
    assign bus.ARVALID   = ar_valid_q;
    assign bus.ARADDR    = araddr_q;
    assign bus.RREADY    = r_ready_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_eeprom_spi_sequencer.sv
// Directed bench: AXI-Lite slave standing in for the SPI peripheral plus a
// byte-level M25AA160C model, driven through write, read, stall, timeout and reset.
module tb_eeprom_spi_sequencer;
    localparam logic [31:0] CFG_VAL = 32'h3000_0000;
    localparam logic [31:0] A_RX    = 32'hFFFF_0000;
    localparam logic [31:0] A_ST    = 32'hFFFF_0004;
    localparam logic [31:0] A_CMD   = 32'hFFFF_0008;
    localparam logic [31:0] A_TX    = 32'hFFFF_000C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eeprom_spi_sequencer_if bus();
    logic [2:0] dbg_state;

    eeprom_spi_sequencer #(
        .CMD_REG_VALUE(CFG_VAL),
        .POLL_LIMIT   (16'd3)
    ) dut (
        .ACLK       (clk),
        .ARESETn    (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] wr_log[$];

    // Slave and peripheral model state
    int          aw_delay = 0;
    int          r_delay = 0;
    logic        force_wip = 1'b0;
    int          aw_cnt;
    logic        aw_got, w_got, r_pend;
    logic [31:0] aw_lat, w_lat, rdata_r, rd_tmp, a_addr, w_data;
    logic        a_now, w_now;
    int          r_cnt;
    logic [7:0]  rx_q[$];
    int          status_busy = 0;
    int          rx_reads = 0;
    int          status_reads = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  mem [256] = '{default: 8'h5C};
    int          spi_pos = 0;
    logic [7:0]  spi_op = 8'h00;
    logic [15:0] ee_addr = 16'h0;
    logic        wel = 1'b0;
    int          wip_cnt = 0;
    logic [7:0]  pend_data = 8'h00;
    logic        has_pend = 1'b0;

    assign bus.AWREADY = bus.AWVALID && (aw_cnt >= aw_delay);
    assign bus.WREADY  = bus.WVALID;
    assign bus.ARREADY = bus.ARVALID && !r_pend;
    assign bus.RVALID  = r_pend && (r_cnt >= r_delay);
    assign bus.RDATA   = rdata_r;

    task automatic spi_xfer(input logic [7:0] mosi, input logic last, output logic [7:0] miso);
        miso = 8'hFF;
        if (spi_pos == 0) begin
            spi_op = mosi;
            if (mosi == 8'h06) wel = 1'b1;
        end else if (spi_op == 8'h02 || spi_op == 8'h03) begin
            if (spi_pos == 1) ee_addr[15:8] = mosi;
            else if (spi_pos == 2) ee_addr[7:0] = mosi;
            else if (spi_op == 8'h02) begin
                pend_data = mosi;
                has_pend  = 1'b1;
            end else begin
                miso = mem[ee_addr[7:0]];
            end
        end else if (spi_op == 8'h05) begin
            miso = {6'b0, wel, (force_wip || wip_cnt > 0)};
        end
        if (last) begin
            if (spi_op == 8'h02 && wel && has_pend) begin
                mem[ee_addr[7:0]] = pend_data;
                wip_cnt = 2;
                wel = 1'b0;
            end
            if (spi_op == 8'h05 && wip_cnt > 0) wip_cnt--;
            spi_pos  = 0;
            has_pend = 1'b0;
        end else begin
            spi_pos++;
        end
    endtask

    task automatic periph_write(input logic [31:0] a, input logic [31:0] d);
        logic [7:0] miso;
        if (a == A_TX) begin
            spi_xfer(d[7:0], d[8], miso);
            rx_q.push_back(miso);
            if (d[8]) status_busy = 1;
        end
    endtask

    task automatic periph_read(input logic [31:0] a, output logic [31:0] d);
        d = 32'h0;
        if (a == A_RX) begin
            rx_reads++;
            if (rx_q.size() > 0) d = {24'h0, rx_q.pop_front()};
            else d = 32'hDEAD_BEEF;
        end else if (a == A_ST) begin
            status_reads++;
            if (status_busy > 0) begin
                d = 32'h1;
                status_busy--;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_cnt  <= 0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            r_pend  <= 1'b0;
            r_cnt   <= 0;
            rdata_r <= 32'h0;
            rx_q.delete();
            spi_pos = 0;
            status_busy = 0;
        end else begin
            if (bus.AWVALID && !bus.AWREADY) aw_cnt <= aw_cnt + 1;
            else aw_cnt <= 0;
            a_now  = bus.AWVALID && bus.AWREADY;
            w_now  = bus.WVALID && bus.WREADY;
            a_addr = aw_got ? aw_lat : bus.AWADDR;
            w_data = w_got ? w_lat : bus.WDATA;
            if ((aw_got || a_now) && (w_got || w_now)) begin
                wr_log.push_back({a_addr, w_data});
                periph_write(a_addr, w_data);
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (a_now) begin
                    aw_got <= 1'b1;
                    aw_lat <= bus.AWADDR;
                end
                if (w_now) begin
                    w_got <= 1'b1;
                    w_lat <= bus.WDATA;
                end
            end
            if (bus.ARVALID && bus.ARREADY) begin
                periph_read(bus.ARADDR, rd_tmp);
                r_pend  <= 1'b1;
                r_cnt   <= 0;
                rdata_r <= rd_tmp;
            end else if (r_pend) begin
                if (bus.RVALID && bus.RREADY) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
            if (bus.DONE) done_cnt++;
            if (bus.ERROR) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] wd, input string tag);
        int n = 0;
        while (!bus.CMD_READY && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_cmd_ready"}, 64'(bus.CMD_READY), 64'd1);
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = wr;
        bus.CMD_ADDR  = addr;
        bus.CMD_WDATA = wd;
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!bus.DONE && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(bus.DONE), 64'd1);
    endtask

    task automatic check_log(input int base, input string tag);
        check({tag, "_nwr"}, 64'(wr_log.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < wr_log.size())
                check($sformatf("%s_wr%0d", tag, i), wr_log[base + i], exp_q[i]);
        end
    endtask

    function automatic logic [63:0] txw(input logic [31:0] d);
        return {A_TX, d};
    endfunction

    initial begin
        int base, rx0, st0, dn0, er0, n, polls;
        logic [31:0] aw_first;
        bus.CMD_VALID = 1'b0;
        bus.CMD_WRITE = 1'b0;
        bus.CMD_ADDR  = 16'h0;
        bus.CMD_WDATA = 8'h0;

        // 1: reset, then configuration write
        repeat (4) @(negedge clk);
        check("rst_ctl", 64'({bus.AWVALID, bus.WVALID, bus.ARVALID, bus.RREADY,
                               bus.CMD_READY, bus.DONE, bus.ERROR}), 64'd0);
        check("rst_rd_data", 64'(bus.RD_DATA), 64'd0);
        check("rst_awaddr", 64'(bus.AWADDR), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("cfg_awvalid", 64'({bus.AWVALID, bus.WVALID}), 64'b11);
        check("cfg_not_ready", 64'(bus.CMD_READY), 64'd0);
        check("cfg_awaddr", 64'(bus.AWADDR), 64'(A_CMD));
        check("cfg_wdata", 64'(bus.WDATA), 64'(CFG_VAL));
        @(negedge clk);
        check("cfg_ready", 64'(bus.CMD_READY), 64'd1);
        exp_q.delete();
        exp_q.push_back({A_CMD, CFG_VAL});
        check_log(0, "cfg");

        // 2: byte write 0xAA to 0x00F0 with two busy RDSR polls
        base = wr_log.size(); rx0 = rx_reads; st0 = status_reads;
        issue(1'b1, 16'h00F0, 8'hAA, "wr");
        wait_done(2000, "wr");
        check("wr_error", 64'(bus.ERROR), 64'd0);
        check("wr_rd_data_held", 64'(bus.RD_DATA), 64'd0);
        exp_q.delete();
        exp_q.push_back(txw(32'h106));
        exp_q.push_back(txw(32'h002));
        exp_q.push_back(txw(32'h000));
        exp_q.push_back(txw(32'h0F0));
        exp_q.push_back(txw(32'h1AA));
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(txw(32'h005));
            exp_q.push_back(txw(32'h100));
        end
        check_log(base, "wr");
        check("wr_rx_reads", 64'(rx_reads - rx0), 64'd11);
        check("wr_status_reads", 64'(status_reads - st0), 64'd10);
        check("wr_eeprom_byte", 64'(mem[8'hF0]), 64'hAA);
        @(negedge clk);
        check("wr_done_pulse", 64'({bus.DONE, bus.CMD_READY}), 64'b01);

        // 3: read back 0x00F0
        base = wr_log.size(); rx0 = rx_reads; st0 = status_reads;
        issue(1'b0, 16'h00F0, 8'h00, "rd");
        wait_done(2000, "rd");
        check("rd_data", 64'(bus.RD_DATA), 64'hAA);
        check("rd_error", 64'(bus.ERROR), 64'd0);
        exp_q.delete();
        exp_q.push_back(txw(32'h003));
        exp_q.push_back(txw(32'h000));
        exp_q.push_back(txw(32'h0F0));
        exp_q.push_back(txw(32'h100));
        check_log(base, "rd");
        check("rd_rx_reads", 64'(rx_reads - rx0), 64'd4);
        check("rd_status_reads", 64'(status_reads - st0), 64'd2);
        @(negedge clk);
        check("rd_done_pulse", 64'(bus.DONE), 64'd0);

        // 4: stalled slave, AWREADY late and RVALID late
        aw_delay = 5; r_delay = 3;
        base = wr_log.size();
        issue(1'b0, 16'h00F0, 8'h00, "stl");
        n = 0;
        while (!bus.AWVALID && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stl_first_valid", 64'({bus.AWVALID, bus.WVALID}), 64'b11);
        aw_first = bus.AWADDR;
        @(negedge clk);
        check("stl_w_dropped", 64'({bus.AWVALID, bus.WVALID}), 64'b10);
        @(negedge clk);
        check("stl_awaddr_stable", 64'(bus.AWADDR), 64'(aw_first));
        wait_done(3000, "stl");
        check("stl_rd_data", 64'(bus.RD_DATA), 64'hAA);
        check_log(base, "stl");
        aw_delay = 0; r_delay = 0;

        // 5: WIP stuck high, poll limit of three
        force_wip = 1'b1;
        base = wr_log.size(); er0 = err_cnt;
        issue(1'b1, 16'h0010, 8'h55, "to");
        wait_done(3000, "to");
        check("to_done_error", 64'({bus.DONE, bus.ERROR}), 64'b11);
        polls = 0;
        for (int i = base; i < wr_log.size(); i++)
            if (wr_log[i] == txw(32'h005)) polls++;
        check("to_polls", 64'(polls), 64'd3);
        check("to_nwr", 64'(wr_log.size() - base), 64'd11);
        @(negedge clk);
        check("to_pulse_end", 64'({bus.DONE, bus.ERROR}), 64'b00);
        check("to_err_count", 64'(err_cnt - er0), 64'd1);
        force_wip = 1'b0;

        // 6: reset during the RX drain of a read
        issue(1'b0, 16'h00F0, 8'h00, "mr");
        n = 0;
        while (!(bus.ARVALID && bus.ARADDR == A_RX) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mr_in_drain", 64'(bus.ARADDR), 64'(A_RX));
        dn0 = done_cnt;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mr_rst_ctl", 64'({bus.AWVALID, bus.WVALID, bus.ARVALID, bus.RREADY,
                                  bus.CMD_READY, bus.DONE, bus.ERROR}), 64'd0);
        check("mr_rst_addr", {bus.AWADDR, bus.ARADDR}, 64'd0);
        check("mr_rst_wdata", 64'(bus.WDATA), 64'd0);
        check("mr_rst_rd_data", 64'(bus.RD_DATA), 64'd0);
        base = wr_log.size();
        rst_n = 1'b1;
        n = 0;
        while (wr_log.size() == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        exp_q.delete();
        exp_q.push_back({A_CMD, CFG_VAL});
        repeat (5) @(negedge clk);
        check_log(base, "mr_cfg");
        check("mr_ready", 64'(bus.CMD_READY), 64'd1);
        check("mr_no_done", 64'(done_cnt - dn0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
